qam16_slicer_ber: RTL and testbench
===================================

Name: qam16_slicer_ber

Overview:
- Downstream consumer of the AWGN channel stage. Takes the noisy 12-bit signed I/Q samples and makes hard-decision 16-QAM Gray demapping to 4 bits per symbol.
- Compares each decision against the transmitted reference bits, which are buffered in an internal FIFO.
- Accumulates bit-error and symbol counts over a frame of NUM_SYM symbols for BER-vs-SNR runs.

Parameters:
- BI, 12, sample width of rx_i/rx_q (two's complement).
- AMP, 256, unit constellation amplitude; ideal levels are ±AMP and ±3·AMP.
- NUM_SYM, 80000, symbols per measurement frame.
- FIFO_DEPTH, 32, reference-bit FIFO entries (power of 2).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse: flush FIFO/pipeline, clear counters/flags, enter RUN.
- ref_valid  in  1  push ref_bits into FIFO.
- ref_bits  in  4  transmitted bits {I1,I0,Q1,Q0}.
- rx_valid  in  1  rx_i/rx_q valid this cycle.
- rx_i  in  BI  received in-phase sample, signed.
- rx_q  in  BI  received quadrature sample, signed.
- dec_valid  out  1  dec_bits valid.
- dec_bits  out  4  hard decision {I1,I0,Q1,Q0}.
- bit_err_count  out  32  accumulated bit errors.
- sym_count  out  32  compared symbols.
- busy  out  1  state==RUN.
- done  out  1  state==DONE.
- fifo_ovf  out  1  sticky: push dropped while full.
- fifo_unf  out  1  sticky: rx symbol arrived in RUN with FIFO empty.

Behaviour:
- Reset (reset==0 at clk edge):
  - State IDLE; FIFO emptied.
  - All outputs 0: dec_valid, dec_bits, bit_err_count, sym_count, busy, done, fifo_ovf, fifo_unf.
  - Reset mid-frame discards everything; no partial results are retained.
- Per-axis slicer, THR = 2·AMP, inputs sign-extended to BI+1 bits:
  - v ≥ THR → level +3, bits 10.
  - 0 ≤ v < THR → level +1, bits 11.
  - −THR ≤ v < 0 → level −1, bits 01.
  - v < −THR → level −3, bits 00.
  - Consequences: exactly 0 → 11; exactly +THR → 10; exactly −THR → 01.
- Demap stage:
  - Stage 1 is registered: dec_valid/dec_bits follow rx_valid by 1 cycle in every state.
  - dec_bits holds its last value when dec_valid=0.
- FSM (IDLE, RUN, DONE):
  - IDLE: start → RUN.
  - RUN: start → RUN (restart). When sym_count reaches NUM_SYM → DONE in the same cycle the last count lands.
  - DONE: start → RUN; otherwise hold.
  - start in any state clears counters and sticky flags, flushes the FIFO and invalidates in-flight compare stages.
- FIFO:
  - ref_valid pushes in any state except a start cycle; flush wins over a simultaneous push.
  - Push while full and no pop in the same cycle: entry dropped, fifo_ovf set.
  - Push and pop in the same cycle while full are both legal; occupancy is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Compare (RUN only):
  - On rx_valid with FIFO non-empty: pop the head, and register it alongside stage 1.
  - Stage 2 computes popcount(dec_bits XOR ref), 0..4.
  - At the end of stage 2, bit_err_count += popcount and sym_count += 1. Counters update 2 cycles after rx_valid.
  - rx_valid with FIFO empty in RUN: no pop, no count, fifo_unf set; dec_valid still produced.
  - In IDLE/DONE: no pops and no counting.
  - Symbols already in flight when the NUM_SYM-th is counted are discarded.
- Counters saturate at 2^32−1 (no wrap).

Test Plan:
- Reset, then start. Push refs 0000..1111. Feed ideal points I,Q ∈ {−768,−256,256,768} in matching Gray order → dec_bits equal refs, bit_err_count=0, sym_count=16 two cycles after the last rx_valid.
- Boundary samples (0, 511, 512, −512, −513, 2047, −2048) on I with Q=0 → I bits 11, 11, 10, 01, 00, 10, 00; Q bits 11.
- Inject deliberate errors: refs all 0000, rx I=Q=+768 (decision 1010) for 10 symbols → bit_err_count=20, sym_count=10.
- NUM_SYM=8, 12 valid symbols → done=1 and busy=0 after the 8th count; sym_count stays 8 and the FIFO keeps the 4 unpopped refs. A subsequent start → counters 0, FIFO empty, busy=1.
- Push 33 refs with no rx (depth 32) → fifo_ovf=1. Then feed rx in RUN with the FIFO drained → fifo_unf=1 and sym_count stops incrementing.
- Assert reset=0 mid-frame with counters nonzero → next cycle all outputs 0 and state IDLE. An rx_valid without start → dec_valid pulses, counters remain 0.

Source files
------------

// File: rtl/qam16_slicer_ber_if.sv
// Sample/reference bus between the AWGN channel model and the 16-QAM
// slicer/BER stage.
//   ref_valid/ref_bits : transmitted reference bits {I1,I0,Q1,Q0}
//   rx_valid/rx_i/rx_q : noisy received I/Q samples (two's complement, BI bits)
//   dec_valid/dec_bits : registered hard decision {I1,I0,Q1,Q0}
// master = stimulus side, slave = slicer side.
interface qam16_slicer_ber_if #(
  parameter int BI = 12
);
  logic                 ref_valid;
  logic [3:0]           ref_bits;
  logic                 rx_valid;
  logic signed [BI-1:0] rx_i;
  logic signed [BI-1:0] rx_q;
  logic                 dec_valid;
  logic [3:0]           dec_bits;

  modport master (
    output ref_valid, ref_bits, rx_valid, rx_i, rx_q,
    input  dec_valid, dec_bits
  );

  modport slave (
    input  ref_valid, ref_bits, rx_valid, rx_i, rx_q,
    output dec_valid, dec_bits
  );
endinterface

// File: rtl/qam16_slicer_ber.sv
// 16-QAM hard-decision Gray demapper with bit-error accounting.
// Each received I/Q pair is sliced per axis into 2 Gray bits (registered,
// one cycle latency). In RUN, every received symbol pops its transmitted
// reference from a FIFO; one cycle later the Hamming distance is added to
// bit_err_count and sym_count is incremented. After NUM_SYM symbols the
// FSM moves to DONE and stops consuming references.
// Ports:
//   clk, reset (sync, active-low), start (one-cycle restart pulse)
//   bus            : slave side of qam16_slicer_ber_if (rx, ref, decision)
//   bit_err_count  : accumulated bit errors (saturating)
//   sym_count      : compared symbols (saturating)
//   busy / done    : state is RUN / DONE
//   fifo_ovf       : sticky, a reference push was dropped while full
//   fifo_unf       : sticky, a symbol arrived in RUN with no reference
module qam16_slicer_ber #(
  parameter int BI         = 12,
  parameter int AMP        = 256,
  parameter int NUM_SYM    = 80000,
  parameter int FIFO_DEPTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  qam16_slicer_ber_if.slave bus,
  output logic [31:0]       bit_err_count,
  output logic [31:0]       sym_count,
  output logic              busy,
  output logic              done,
  output logic              fifo_ovf,
  output logic              fifo_unf
);

  localparam int                AW   = $clog2(FIFO_DEPTH);
  localparam logic signed [BI:0] THR = (BI+1)'(2 * AMP);
  localparam logic [31:0]       LAST = 32'(NUM_SYM - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [3:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        vld_p1, cmp_p1;
  logic [3:0]  dec_bits_p1, ref_p1;
  logic        empty, full, finishing, run_eff, push, pop, wr_en;

  // Decision regions: [THR,inf) -> +3, [0,THR) -> +1, [-THR,0) -> -1, else -3.
  function automatic logic [1:0] slice_axis(input logic signed [BI-1:0] v);
    logic signed [BI:0] x;
    x = {v[BI-1], v};
    if (x >= THR)       return 2'b10;
    else if (!x[BI])    return 2'b11;
    else if (x >= -THR) return 2'b01;
    else                return 2'b00;
  endfunction

  function automatic logic [2:0] popcount4(input logic [3:0] b);
    return 3'(b[0]) + 3'(b[1]) + 3'(b[2]) + 3'(b[3]);
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [2:0] inc);
    logic [32:0] s;
    s = {1'b0, a} + 33'(inc);
    return s[32] ? '1 : s[31:0];
  endfunction

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  // The edge that lands the last count must not pop another reference,
  // otherwise a trailing symbol would silently consume one.
  assign finishing = (state == RUN) && cmp_p1 && (sym_count == LAST);
  assign run_eff   = (state == RUN) && !finishing && !start;
  assign pop       = run_eff && bus.rx_valid && !empty;
  assign push      = bus.ref_valid && !start;
  assign wr_en     = push && (!full || pop);

  assign bus.dec_valid = vld_p1;
  assign bus.dec_bits  = dec_bits_p1;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= bus.ref_bits;
    if (pop)   ref_p1 <= mem[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      vld_p1        <= 1'b0;
      dec_bits_p1   <= '0;
      cmp_p1        <= 1'b0;
      bit_err_count <= '0;
      sym_count     <= '0;
      fifo_ovf      <= 1'b0;
      fifo_unf      <= 1'b0;
    end else begin
      // Stage 1: slice and register the decision in every state
      vld_p1 <= bus.rx_valid;
      if (bus.rx_valid)
        dec_bits_p1 <= {slice_axis(bus.rx_i), slice_axis(bus.rx_q)};

      if (start) begin
        state         <= RUN;
        busy          <= 1'b1;
        done          <= 1'b0;
        wr_ptr        <= '0;
        rd_ptr        <= '0;
        cmp_p1        <= 1'b0;
        bit_err_count <= '0;
        sym_count     <= '0;
        fifo_ovf      <= 1'b0;
        fifo_unf      <= 1'b0;
      end else begin
        if (wr_en)                   wr_ptr   <= wr_ptr + 1'b1;
        if (push && full && !pop)    fifo_ovf <= 1'b1;
        if (pop)                     rd_ptr   <= rd_ptr + 1'b1;
        if (run_eff && bus.rx_valid && empty) fifo_unf <= 1'b1;
        cmp_p1 <= pop;

        // Stage 2: Hamming distance against the popped reference
        if ((state == RUN) && cmp_p1) begin
          bit_err_count <= sat_add(bit_err_count, popcount4(dec_bits_p1 ^ ref_p1));
          sym_count     <= sat_add(sym_count, 3'd1);
        end
        if (finishing) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_qam16_slicer_ber.sv
module tb_qam16_slicer_ber;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  always #5 clk = ~clk;

  qam16_slicer_ber_if #(.BI(12)) bus_a ();
  qam16_slicer_ber_if #(.BI(12)) bus_b ();

  logic [31:0] err_a, sym_a, err_b, sym_b;
  logic busy_a, done_a, ovf_a, unf_a, busy_b, done_b, ovf_b, unf_b;

  qam16_slicer_ber #(.BI(12), .AMP(256), .NUM_SYM(80000), .FIFO_DEPTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus_a),
    .bit_err_count(err_a), .sym_count(sym_a), .busy(busy_a), .done(done_a),
    .fifo_ovf(ovf_a), .fifo_unf(unf_a));

  qam16_slicer_ber #(.BI(12), .AMP(256), .NUM_SYM(8), .FIFO_DEPTH(32)) dut8 (
    .clk(clk), .reset(reset), .start(start), .bus(bus_b),
    .bit_err_count(err_b), .sym_count(sym_b), .busy(busy_b), .done(done_b),
    .fifo_ovf(ovf_b), .fifo_unf(unf_b));

  int errors = 0;
  int checks = 0;

  // Reference model: nearest ideal level (ties go to the larger level),
  // then Gray label of that level.
  function automatic logic [1:0] model_axis(input int v);
    int lv [4];
    logic [1:0] g [4];
    int bd, d;
    logic [1:0] best;
    lv = '{-3, -1, 1, 3};
    g  = '{2'b00, 2'b01, 2'b11, 2'b10};
    bd = 0;
    best = 2'b00;
    for (int k = 0; k < 4; k++) begin
      d = v - lv[k] * 256;
      if (d < 0) d = -d;
      if (k == 0 || d <= bd) begin
        bd = d;
        best = g[k];
      end
    end
    return best;
  endfunction

  function automatic logic [3:0] model_dec(input int i, input int q);
    return {model_axis(i), model_axis(q)};
  endfunction

  function automatic int level_of(input logic [1:0] g);
    case (g)
      2'b00:   return -768;
      2'b01:   return -256;
      2'b11:   return 256;
      default: return 768;
    endcase
  endfunction

  function automatic int rnd_sample();
    return int'($urandom_range(4095)) - 2048;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rx(input logic v, input int i, input int q);
    bus_a.rx_valid = v; bus_a.rx_i = 12'(i); bus_a.rx_q = 12'(q);
    bus_b.rx_valid = v; bus_b.rx_i = 12'(i); bus_b.rx_q = 12'(q);
  endtask

  task automatic drive_ref(input logic v, input logic [3:0] b);
    bus_a.ref_valid = v; bus_a.ref_bits = b;
    bus_b.ref_valid = v; bus_b.ref_bits = b;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive_rx(1'b1, 768, 768);
    cycle();
    cycle();
    drive_rx(1'b0, 0, 0);
    checks++;
    if ({bus_a.dec_valid, bus_a.dec_bits} !== 5'd0) begin
      errors++; $display("FAIL reset_dec: got %0h expected 0", {bus_a.dec_valid, bus_a.dec_bits});
    end
    checks++;
    if ({err_a, sym_a} !== 64'd0) begin
      errors++; $display("FAIL reset_counts: got err=%0d sym=%0d expected 0 0", err_a, sym_a);
    end
    checks++;
    if ({busy_a, done_a, ovf_a, unf_a} !== 4'd0) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {busy_a, done_a, ovf_a, unf_a});
    end
    reset = 1'b1;
    cycle();
  endtask

  task automatic test_ideal();
    pulse_start();
    checks++;
    if (busy_a !== 1'b1) begin
      errors++; $display("FAIL ideal_busy: got %b expected 1", busy_a);
    end
    for (int r = 0; r < 16; r++) begin
      drive_ref(1'b1, 4'(r));
      cycle();
    end
    drive_ref(1'b0, 4'd0);
    for (int r = 0; r < 16; r++) begin
      logic [3:0] rb;
      rb = 4'(r);
      drive_rx(1'b1, level_of(rb[3:2]), level_of(rb[1:0]));
      cycle();
      checks++;
      if (bus_a.dec_valid !== 1'b1 || bus_a.dec_bits !== rb) begin
        errors++; $display("FAIL ideal_dec[%0d]: got v=%b bits=%b expected v=1 bits=%b", r, bus_a.dec_valid, bus_a.dec_bits, rb);
      end
    end
    drive_rx(1'b0, 0, 0);
    cycle();
    checks++;
    if (sym_a !== 32'd16 || err_a !== 32'd0) begin
      errors++; $display("FAIL ideal_counts: got sym=%0d err=%0d expected 16 0", sym_a, err_a);
    end
  endtask

  task automatic test_boundary();
    int vals [7];
    logic [1:0] ib [7];
    vals = '{0, 511, 512, -512, -513, 2047, -2048};
    ib   = '{2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b10, 2'b00};
    for (int k = 0; k < 7; k++) begin
      drive_rx(1'b1, vals[k], 0);
      cycle();
      checks++;
      if (bus_a.dec_bits !== {ib[k], 2'b11} || bus_a.dec_bits !== model_dec(vals[k], 0)) begin
        errors++; $display("FAIL boundary[%0d]: got %b expected %b", vals[k], bus_a.dec_bits, {ib[k], 2'b11});
      end
    end
    drive_rx(1'b0, 0, 0);
    cycle();
  endtask

  task automatic test_errors();
    pulse_start();
    for (int k = 0; k < 10; k++) begin
      drive_ref(1'b1, 4'b0000);
      cycle();
    end
    drive_ref(1'b0, 4'd0);
    for (int k = 0; k < 10; k++) begin
      drive_rx(1'b1, 768, 768);
      cycle();
    end
    drive_rx(1'b0, 0, 0);
    checks++;
    if (bus_a.dec_bits !== 4'b1010) begin
      errors++; $display("FAIL errors_dec: got %b expected 1010", bus_a.dec_bits);
    end
    cycle();
    checks++;
    if (err_a !== 32'd20 || sym_a !== 32'd10) begin
      errors++; $display("FAIL errors_counts: got err=%0d sym=%0d expected 20 10", err_a, sym_a);
    end
  endtask

  task automatic test_random();
    logic [3:0] refq [$];
    logic [3:0] last, exp_d, rf;
    int exp_err, exp_sym, i, q;
    pulse_start();
    exp_err = 0;
    exp_sym = 0;
    for (int k = 0; k < 24; k++) begin
      rf = 4'($urandom_range(15));
      refq.push_back(rf);
      drive_ref(1'b1, rf);
      cycle();
    end
    drive_ref(1'b0, 4'd0);
    last = bus_a.dec_bits;
    while (refq.size() > 0) begin
      if ($urandom_range(3) != 0) begin
        i = rnd_sample();
        q = rnd_sample();
        exp_d = model_dec(i, q);
        rf = refq.pop_front();
        exp_err += $countones(exp_d ^ rf);
        exp_sym++;
        drive_rx(1'b1, i, q);
        cycle();
        last = exp_d;
        checks++;
        if (bus_a.dec_valid !== 1'b1 || bus_a.dec_bits !== exp_d) begin
          errors++; $display("FAIL random_dec: I=%0d Q=%0d got v=%b bits=%b expected v=1 bits=%b", i, q, bus_a.dec_valid, bus_a.dec_bits, exp_d);
        end
      end else begin
        drive_rx(1'b0, rnd_sample(), rnd_sample());
        cycle();
        checks++;
        if (bus_a.dec_valid !== 1'b0 || bus_a.dec_bits !== last) begin
          errors++; $display("FAIL random_hold: got v=%b bits=%b expected v=0 bits=%b", bus_a.dec_valid, bus_a.dec_bits, last);
        end
      end
    end
    drive_rx(1'b0, 0, 0);
    cycle();
    checks++;
    if (err_a !== 32'(exp_err) || sym_a !== 32'(exp_sym)) begin
      errors++; $display("FAIL random_counts: got err=%0d sym=%0d expected %0d %0d", err_a, sym_a, exp_err, exp_sym);
    end
  endtask

  task automatic test_done();
    logic [3:0] rf, d;
    int e8, e12, i, q;
    logic [3:0] refs [12];
    pulse_start();
    e8 = 0;
    e12 = 0;
    for (int k = 0; k < 12; k++) begin
      refs[k] = 4'($urandom_range(15));
      drive_ref(1'b1, refs[k]);
      cycle();
    end
    drive_ref(1'b0, 4'd0);
    for (int k = 0; k < 12; k++) begin
      i = rnd_sample();
      q = rnd_sample();
      d = model_dec(i, q);
      if (k < 8) e8 += $countones(d ^ refs[k]);
      e12 += $countones(d ^ refs[k]);
      drive_rx(1'b1, i, q);
      cycle();
    end
    drive_rx(1'b0, 0, 0);
    cycle();
    cycle();
    checks++;
    if (done_b !== 1'b1 || busy_b !== 1'b0) begin
      errors++; $display("FAIL done_state: got done=%b busy=%b expected 1 0", done_b, busy_b);
    end
    checks++;
    if (sym_b !== 32'd8 || err_b !== 32'(e8)) begin
      errors++; $display("FAIL done_counts: got sym=%0d err=%0d expected 8 %0d", sym_b, err_b, e8);
    end
    checks++;
    if (sym_a !== 32'd12 || err_a !== 32'(e12)) begin
      errors++; $display("FAIL long_frame_counts: got sym=%0d err=%0d expected 12 %0d", sym_a, err_a, e12);
    end
    // 4 unpopped refs + 28 fills the FIFO exactly; one more overflows
    for (int k = 0; k < 28; k++) begin
      rf = 4'(k);
      drive_ref(1'b1, rf);
      cycle();
    end
    drive_ref(1'b0, 4'd0);
    checks++;
    if (ovf_b !== 1'b0) begin
      errors++; $display("FAIL done_fifo_kept: got ovf=%b expected 0", ovf_b);
    end
    drive_ref(1'b1, 4'd5);
    cycle();
    drive_ref(1'b0, 4'd0);
    checks++;
    if (ovf_b !== 1'b1) begin
      errors++; $display("FAIL done_fifo_full: got ovf=%b expected 1", ovf_b);
    end
    pulse_start();
    checks++;
    if (sym_b !== 32'd0 || err_b !== 32'd0 || busy_b !== 1'b1 || done_b !== 1'b0 || ovf_b !== 1'b0) begin
      errors++; $display("FAIL restart: got sym=%0d err=%0d busy=%b done=%b ovf=%b expected 0 0 1 0 0", sym_b, err_b, busy_b, done_b, ovf_b);
    end
    drive_rx(1'b1, 0, 0);
    cycle();
    drive_rx(1'b0, 0, 0);
    cycle();
    checks++;
    if (unf_b !== 1'b1 || sym_b !== 32'd0) begin
      errors++; $display("FAIL restart_flushed: got unf=%b sym=%0d expected 1 0", unf_b, sym_b);
    end
  endtask

  task automatic test_overflow();
    pulse_start();
    for (int k = 0; k < 32; k++) begin
      drive_ref(1'b1, 4'($urandom_range(15)));
      cycle();
    end
    drive_ref(1'b0, 4'd0);
    checks++;
    if (ovf_a !== 1'b0) begin
      errors++; $display("FAIL ovf_at_depth: got %b expected 0", ovf_a);
    end
    // full with simultaneous push and pop: both accepted
    drive_ref(1'b1, 4'd3);
    drive_rx(1'b1, 256, 256);
    cycle();
    drive_rx(1'b0, 0, 0);
    checks++;
    if (ovf_a !== 1'b0) begin
      errors++; $display("FAIL ovf_push_pop: got %b expected 0", ovf_a);
    end
    cycle();
    drive_ref(1'b0, 4'd0);
    checks++;
    if (ovf_a !== 1'b1) begin
      errors++; $display("FAIL ovf_drop: got %b expected 1", ovf_a);
    end
    for (int k = 0; k < 32; k++) begin
      drive_rx(1'b1, rnd_sample(), rnd_sample());
      cycle();
    end
    drive_rx(1'b0, 0, 0);
    cycle();
    checks++;
    if (sym_a !== 32'd33 || unf_a !== 1'b0) begin
      errors++; $display("FAIL drain: got sym=%0d unf=%b expected 33 0", sym_a, unf_a);
    end
    for (int k = 0; k < 3; k++) begin
      drive_rx(1'b1, rnd_sample(), rnd_sample());
      cycle();
    end
    drive_rx(1'b0, 0, 0);
    cycle();
    cycle();
    checks++;
    if (unf_a !== 1'b1 || sym_a !== 32'd33) begin
      errors++; $display("FAIL underflow: got unf=%b sym=%0d expected 1 33", unf_a, sym_a);
    end
  endtask

  task automatic test_midreset();
    pulse_start();
    for (int k = 0; k < 5; k++) begin
      drive_ref(1'b1, 4'd0);
      cycle();
    end
    drive_ref(1'b0, 4'd0);
    for (int k = 0; k < 6; k++) begin
      drive_rx(1'b1, -768, 768);
      cycle();
    end
    drive_rx(1'b0, 0, 0);
    cycle();
    checks++;
    if (sym_a !== 32'd5 || err_a !== 32'd5 || unf_a !== 1'b1) begin
      errors++; $display("FAIL pre_reset: got sym=%0d err=%0d unf=%b expected 5 5 1", sym_a, err_a, unf_a);
    end
    reset = 1'b0;
    drive_rx(1'b1, 768, 768);
    cycle();
    checks++;
    if ({bus_a.dec_valid, bus_a.dec_bits, err_a, sym_a, busy_a, done_a, ovf_a, unf_a} !== '0) begin
      errors++; $display("FAIL midreset: got v=%b bits=%b err=%0d sym=%0d busy=%b done=%b ovf=%b unf=%b expected all 0",
        bus_a.dec_valid, bus_a.dec_bits, err_a, sym_a, busy_a, done_a, ovf_a, unf_a);
    end
    reset = 1'b1;
    cycle();
    checks++;
    if (bus_a.dec_valid !== 1'b1 || bus_a.dec_bits !== 4'b1010) begin
      errors++; $display("FAIL idle_dec: got v=%b bits=%b expected 1 1010", bus_a.dec_valid, bus_a.dec_bits);
    end
    drive_rx(1'b0, 0, 0);
    cycle();
    cycle();
    checks++;
    if (bus_a.dec_valid !== 1'b0 || sym_a !== 32'd0 || err_a !== 32'd0 || busy_a !== 1'b0) begin
      errors++; $display("FAIL idle_nocount: got v=%b sym=%0d err=%0d busy=%b expected 0 0 0 0", bus_a.dec_valid, sym_a, err_a, busy_a);
    end
  endtask

  initial begin
    drive_rx(1'b0, 0, 0);
    drive_ref(1'b0, 4'd0);
    test_reset();
    test_ideal();
    test_boundary();
    test_errors();
    test_random();
    test_done();
    test_overflow();
    test_midreset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
